// File: rtl/prod_bcd_conv.sv
// rtl/prod_bcd_conv.sv - sequential double-dabble binary-to-packed-BCD converter
module prod_bcd_conv #(
    parameter int IN_W   = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CNT_W = $clog2(IN_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_t;

    state_t                state_q, state_d;
    logic [IN_W-1:0]       bin_sh_q, bin_sh_d;
    logic [4*DIGITS-1:0]   scr_q, scr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic [4*DIGITS-1:0]   adj;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            bin_sh_q <= '0;
            scr_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            bcd_q    <= '0;
        end else begin
            state_q  <= state_d;
            bin_sh_q <= bin_sh_d;
            scr_q    <= scr_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            bcd_q    <= bcd_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bin_sh_d = bin_sh_q;
        scr_d    = scr_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        bcd_d    = bcd_q;
        adj      = scr_q;

        // Add-3 correction is per digit; a corrected digit never exceeds 4 bits.
        for (int i = 0; i < DIGITS; i++) begin
            if (scr_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_sh_d = bin;
                    scr_d    = '0;
                    cnt_d    = CNT_W'(IN_W);
                    busy_d   = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                {scr_d, bin_sh_d} = {adj[4*DIGITS-2:0], bin_sh_q, 1'b0};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                bcd_d   = scr_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: tb/tb_prod_bcd_conv.sv
// tb/tb_prod_bcd_conv.sv - scoreboard bench for prod_bcd_conv
module tb_prod_bcd_conv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] bin = 16'd0;
    logic        busy;
    logic        done;
    logic [19:0] bcd;

    int          checks = 0;
    int          errors = 0;
    logic [19:0] exp_q[$];
    logic        done_prev = 1'b0;

    always #5 clk = ~clk;

    prod_bcd_conv #(.IN_W(16), .DIGITS(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    function automatic logic [19:0] to_bcd(input int unsigned v);
        logic [19:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int d = 0; d < 5; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Scoreboard: every done pulse pops one expected result.
    always @(negedge clk) begin
        logic [19:0] e;
        if (!rst_n) begin
            done_prev = 1'b0;
        end else begin
            if (done) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: got done with bcd=%05h, required no done pulse", bcd);
                end else begin
                    e = exp_q.pop_front();
                    if (bcd !== e) begin
                        errors++;
                        $display("FAIL bcd_result: got %05h, required %05h", bcd, e);
                    end
                end
                checks++;
                if (done_prev) begin
                    errors++;
                    $display("FAIL done_width: done high 2 cycles, required 1");
                end
            end
            done_prev = done;
        end
    end

    // One conversion: returns edges from start sample to done, busy-high samples, bcd-held flag.
    task automatic convert(input logic [15:0] v, output int lat, output int bcnt, output bit held);
        logic [19:0] prev;
        @(posedge clk); #1;
        bin   = v;
        start = 1'b1;
        exp_q.push_back(to_bcd(v));
        prev  = bcd;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = -1;
        bcnt  = 0;
        held  = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                lat = n - 1;
                break;
            end
            if (bcd !== prev) held = 1'b0;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, bcd} !== 22'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b bcd=%05h, required 0 0 00000", busy, done, bcd);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_zero;
        int lat, bcnt;
        bit held;
        convert(16'd0, lat, bcnt, held);
        checks++;
        if (lat !== 17) begin
            errors++;
            $display("FAIL zero_latency: got %0d, required 17", lat);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL zero_after_done: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_max;
        int lat, bcnt;
        bit held;
        convert(16'd65535, lat, bcnt, held);
        checks++;
        if (bcnt !== 17 || lat !== 17) begin
            errors++;
            $display("FAIL max_busy: busy_cycles=%0d latency=%0d, required 17 17", bcnt, lat);
        end
    endtask

    task automatic test_values;
        int lat, bcnt;
        bit held;
        convert(16'd1234, lat, bcnt, held);
        convert(16'd9, lat, bcnt, held);
        checks++;
        if (!held || lat !== 17) begin
            errors++;
            $display("FAIL hold_prev: held=%0d latency=%0d, required 1 17", held, lat);
        end
    endtask

    task automatic test_back_to_back;
        int dones, first_n, second_n;
        dones = 0;
        first_n = -1;
        second_n = -1;
        @(posedge clk); #1;
        bin   = 16'd500;
        start = 1'b1;
        exp_q.push_back(to_bcd(500));
        exp_q.push_back(to_bcd(42));
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n == 8) bin = 16'd42;
            if (done) begin
                dones++;
                if (dones == 1) first_n = n;
                if (dones == 2) begin
                    second_n = n;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        checks++;
        if (dones !== 2 || first_n !== 19 || second_n !== 37) begin
            errors++;
            $display("FAIL back_to_back: dones=%0d at %0d,%0d, required 2 at 19,37", dones, first_n, second_n);
        end
    endtask

    task automatic test_reset_abort;
        int lat, bcnt;
        bit held;
        @(posedge clk); #1;
        bin   = 16'd777;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, bcd} !== 22'd0) begin
            errors++;
            $display("FAIL abort_state: busy=%b done=%b bcd=%05h, required 0 0 00000", busy, done, bcd);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bcd !== 20'd0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b bcd=%05h, required 0 00000", busy, bcd);
        end
        convert(16'd777, lat, bcnt, held);
        checks++;
        if (lat !== 17) begin
            errors++;
            $display("FAIL restart_latency: got %0d, required 17", lat);
        end
    endtask

    task automatic test_sweep;
        int lat, bcnt;
        bit held;
        logic [15:0] v;
        logic [15:0] special[6];
        special = '{16'd9, 16'd10, 16'd99, 16'd100, 16'd9999, 16'd10000};
        for (int i = 0; i < 1000; i++) begin
            v = (i < 6) ? special[i] : 16'($urandom_range(0, 65535));
            convert(v, lat, bcnt, held);
            checks++;
            if (lat !== 17 || bcnt !== 17 || !held) begin
                errors++;
                $display("FAIL sweep_timing: bin=%0d latency=%0d busy=%0d held=%0d, required 17 17 1", v, lat, bcnt, held);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_max();
        test_values();
        test_back_to_back();
        test_reset_abort();
        test_sweep();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_results: %0d outstanding, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
